mp64_mem_resp: RTL and testbench
================================

// Module: mp64_mem_resp
// PURPOSE
//   Responder end of the arbiter's memory request channel. Serves mem_req from on-chip BRAM
//   when the address falls in the BRAM window. Forwards all other addresses to the external
//   memory port. Returns mem_rdata with a one-cycle mem_ack pulse. Sits between the bus
//   arbiter and BRAM / external memory controller.
// PARAMETERS
//   BRAM_AW      14       BRAM depth = 2**BRAM_AW 64-bit words (default 128 KiB)
//   BRAM_BASE    64'h0    byte base address of BRAM window (aligned to window size)
//   EXT_TIMEOUT  1024     cycles to wait for ext_ack before an aborted response
// PORTS
//   clk        in   1   single clock, rising edge
//   rst        in   1   asynchronous, active-high reset
//   mem_req    in   1   request; held high with fields stable until mem_ack seen
//   mem_addr   in   64  byte address
//   mem_wdata  in   64  write data, right-justified
//   mem_wen    in   1   1 = write, 0 = read
//   mem_size   in   2   0 = byte, 1 = 16b, 2 = 32b, 3 = 64b
//   mem_rdata  out  64  read data, right-justified, zero-extended; valid while mem_ack = 1
//   mem_ack    out  1   single-cycle completion pulse
//   mem_err    out  1   pulses with mem_ack when an external access timed out
//   ext_req    out  1   external request, held until ext_ack or timeout
//   ext_addr   out  64  external byte address (mem_addr passed through)
//   ext_wdata  out  64  external write data
//   ext_wen    out  1   external write enable
//   ext_size   out  2   external access size
//   ext_rdata  in   64  external read data, sampled when ext_ack = 1
//   ext_ack    in   1   external completion, may be high for one or more cycles
// BEHAVIOUR
// - Reset: all outputs are 0 and state is S_IDLE. BRAM contents are not cleared.
//   Reset mid-transaction drops ext_req and loses the pending ack.
// - in_bram = (mem_addr - BRAM_BASE) < 8*2**BRAM_AW, computed with 64-bit unsigned
//   arithmetic (an address below the base wraps high and is therefore external).
// - lane = mem_addr[2:0] with the low log2(bytes) bits forced to 0. Misaligned addresses
//   are truncated to natural alignment.
// - Byte enables = size-mask << lane. Write data = mem_wdata << 8*lane.
// - Read data = (word >> 8*lane) masked to the size.
// - State S_IDLE:
//   - Stays idle while mem_req = 0.
//   - mem_req & in_bram & wen: the BRAM byte-write is done at this edge, mem_ack = 1 in
//     the next cycle, go to S_DONE. Write latency is 1 cycle.
//   - mem_req & in_bram & !wen: BRAM read issued, go to S_BRAM.
//   - mem_req & !in_bram: ext_* fields registered, ext_req = 1, timer cleared, go to S_EXT.
// - State S_BRAM: the BRAM word is valid. Register the formatted mem_rdata, set mem_ack = 1,
//   go to S_DONE. mem_ack is high 2 cycles after the request is sampled.
// - State S_EXT:
//   - On ext_ack: capture ext_rdata (formatted as for BRAM on reads, 0 on writes),
//     ext_req = 0, mem_ack = 1, go to S_DONE.
//   - When the timer reaches EXT_TIMEOUT-1 with no ext_ack: ext_req = 0, mem_rdata = all
//     ones, mem_ack = 1, mem_err = 1, go to S_DONE.
//   - If ext_ack arrives on the timeout cycle, ext_ack wins.
// - State S_DONE: this is the cycle in which mem_ack is high. mem_req is still high here and
//   is ignored (the arbiter drops it on this edge). mem_ack and mem_err clear; go to S_IDLE.
// - Exactly one mem_ack per accepted request. No request is accepted in S_BRAM, S_EXT or
//   S_DONE.
// - mem_rdata is held after ack until the next completion. ext_* fields are stable while
//   ext_req = 1.
// TESTING
// - Write 64'h1122334455667788 to addr 0x10 (size 3). Read addr 0x12, size 1.
//   -> write ack in cycle 1; read rdata = 64'h5566, ack in cycle 2.
// - Byte write 0xAB to addr 0x17, then 64-bit read of 0x10 -> 64'hAB22334455667788.
// - Read addr 0x8000_0000 with the external model acking after 5 cycles with
//   64'hDEADBEEF00000000 -> ext_req high for 5 cycles, then mem_ack with that data,
//   mem_err = 0.
// - External model never acks -> ext_req drops after EXT_TIMEOUT cycles; mem_ack = 1,
//   mem_err = 1, rdata = 64'hFFFF_FFFF_FFFF_FFFF.
// - Back-to-back requests in arbiter style (req held through the ack cycle)
//   -> exactly one ack per request, no duplicate BRAM write.
//   Also: BRAM_BASE = 0x1000 with addr 0x0FF8 -> routed external (wrap-around check).
// - Assert rst while in S_EXT -> ext_req, mem_ack and mem_err are 0 immediately. After
//   release, a new BRAM read completes normally.

Source files
------------

// File: rtl/mp64_mem_resp_if.sv
// Memory request channel from the bus arbiter plus the external memory port behind the responder.
// slave = responder side; master = arbiter and external memory side.
interface mp64_mem_resp_if;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_wen;
    logic [1:0]  mem_size;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic        mem_err;
    logic        ext_req;
    logic [63:0] ext_addr;
    logic [63:0] ext_wdata;
    logic        ext_wen;
    logic [1:0]  ext_size;
    logic [63:0] ext_rdata;
    logic        ext_ack;

    modport slave (
        input  mem_req, mem_addr, mem_wdata, mem_wen, mem_size,
        output mem_rdata, mem_ack, mem_err,
        output ext_req, ext_addr, ext_wdata, ext_wen, ext_size,
        input  ext_rdata, ext_ack
    );

    modport master (
        output mem_req, mem_addr, mem_wdata, mem_wen, mem_size,
        input  mem_rdata, mem_ack, mem_err,
        input  ext_req, ext_addr, ext_wdata, ext_wen, ext_size,
        output ext_rdata, ext_ack
    );
endinterface

// File: rtl/mp64_mem_resp.sv
// Memory responder: BRAM window served locally, other addresses forwarded to ext port with timeout.
// Latency: BRAM write 1 cycle, BRAM read 2 cycles, ext = ext_ack + 1; requester holds mem_req until mem_ack.
module mp64_mem_resp #(
    parameter int          BRAM_AW     = 14,
    parameter logic [63:0] BRAM_BASE   = 64'h0,
    parameter int          EXT_TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           rst,
    mp64_mem_resp_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_BRAM, S_EXT, S_DONE} state_t;

    localparam logic [63:0] WIN_BYTES = 64'd8 << BRAM_AW;
    localparam int          TW        = $clog2(EXT_TIMEOUT + 1);

    function automatic logic [2:0] lane_of(input logic [2:0] a, input logic [1:0] sz);
        case (sz)
            2'd0:    return a;
            2'd1:    return {a[2:1], 1'b0};
            2'd2:    return {a[2], 2'b00};
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] be_of(input logic [1:0] sz);
        case (sz)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] fmt(input logic [63:0] w, input logic [2:0] ln, input logic [1:0] sz);
        logic [63:0] m;
        case (sz)
            2'd0:    m = 64'h0000_0000_0000_00FF;
            2'd1:    m = 64'h0000_0000_0000_FFFF;
            2'd2:    m = 64'h0000_0000_FFFF_FFFF;
            default: m = '1;
        endcase
        return (w >> {ln, 3'b000}) & m;
    endfunction

    state_t              state;
    logic [TW-1:0]       timer;
    logic [2:0]          lane_q;
    logic [1:0]          size_q;
    logic                wen_q;
    logic [63:0]         rd_word;
    logic [63:0]         bram [0:2**BRAM_AW-1];

    logic [63:0]         off;
    logic                in_bram;
    logic [BRAM_AW-1:0]  idx;
    logic [2:0]          lane;
    logic [7:0]          be;
    logic [63:0]         wdata_sh;
    logic                accept;
    logic                bram_we;

    // Unsigned wrap makes addresses below the base land far outside the window.
    assign off      = bus.mem_addr - BRAM_BASE;
    assign in_bram  = off < WIN_BYTES;
    assign idx      = off[BRAM_AW+2:3];
    assign lane     = lane_of(bus.mem_addr[2:0], bus.mem_size);
    assign be       = be_of(bus.mem_size) << lane;
    assign wdata_sh = bus.mem_wdata << {lane, 3'b000};
    assign accept   = (state == S_IDLE) && bus.mem_req;
    assign bram_we  = accept && in_bram && bus.mem_wen;

    always_ff @(posedge clk) begin
        if (bram_we) begin
            for (int i = 0; i < 8; i++) begin
                if (be[i]) bram[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
        rd_word <= bram[idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            timer         <= '0;
            lane_q        <= '0;
            size_q        <= '0;
            wen_q         <= 1'b0;
            bus.mem_rdata <= '0;
            bus.mem_ack   <= 1'b0;
            bus.mem_err   <= 1'b0;
            bus.ext_req   <= 1'b0;
            bus.ext_addr  <= '0;
            bus.ext_wdata <= '0;
            bus.ext_wen   <= 1'b0;
            bus.ext_size  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lane_q <= lane;
                        size_q <= bus.mem_size;
                        wen_q  <= bus.mem_wen;
                        if (in_bram && bus.mem_wen) begin
                            bus.mem_rdata <= '0;
                            bus.mem_ack   <= 1'b1;
                            state         <= S_DONE;
                        end else if (in_bram) begin
                            state <= S_BRAM;
                        end else begin
                            bus.ext_req   <= 1'b1;
                            bus.ext_addr  <= bus.mem_addr;
                            bus.ext_wdata <= bus.mem_wdata;
                            bus.ext_wen   <= bus.mem_wen;
                            bus.ext_size  <= bus.mem_size;
                            timer         <= '0;
                            state         <= S_EXT;
                        end
                    end
                end
                S_BRAM: begin
                    bus.mem_rdata <= fmt(rd_word, lane_q, size_q);
                    bus.mem_ack   <= 1'b1;
                    state         <= S_DONE;
                end
                S_EXT: begin
                    // ext_ack takes priority over a timeout on the same cycle.
                    if (bus.ext_ack) begin
                        bus.ext_req   <= 1'b0;
                        bus.mem_rdata <= wen_q ? 64'h0 : fmt(bus.ext_rdata, lane_q, size_q);
                        bus.mem_ack   <= 1'b1;
                        state         <= S_DONE;
                    end else if (timer == TW'(EXT_TIMEOUT - 1)) begin
                        bus.ext_req   <= 1'b0;
                        bus.mem_rdata <= '1;
                        bus.mem_ack   <= 1'b1;
                        bus.mem_err   <= 1'b1;
                        state         <= S_DONE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_DONE: begin
                    bus.mem_ack <= 1'b0;
                    bus.mem_err <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mp64_mem_resp.sv
// Directed bench for mp64_mem_resp: BRAM lanes, external acks/timeouts, back-to-back, reset.
module tb_mp64_mem_resp;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   ack_count = 0;
    int   ext_delay = 0;
    int   ext_cnt = 0;
    int   ext_hi_last = 0;
    logic [63:0] ext_addr_seen = '0;
    logic        ext_wen_seen = 1'b0;

    always #5 clk = ~clk;

    mp64_mem_resp_if bus0 ();
    mp64_mem_resp_if bus1 ();

    mp64_mem_resp #(.BRAM_AW(10), .BRAM_BASE(64'h0), .EXT_TIMEOUT(32)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0));
    mp64_mem_resp #(.BRAM_AW(4), .BRAM_BASE(64'h1000), .EXT_TIMEOUT(8)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));

    // External memory model: acks on the ext_delay-th cycle of ext_req; never when ext_delay is 0.
    always @(posedge clk) begin
        #2;
        if (bus0.ext_req) begin
            ext_cnt++;
            ext_hi_last   = ext_cnt;
            ext_addr_seen = bus0.ext_addr;
            ext_wen_seen  = bus0.ext_wen;
            bus0.ext_ack  = (ext_delay != 0) && (ext_cnt == ext_delay);
        end else begin
            ext_cnt      = 0;
            bus0.ext_ack = 1'b0;
        end
    end

    always @(posedge clk) begin
        #3;
        if (bus0.mem_ack) ack_count++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end, time %0t", $time);
        $fatal(1);
    end

    // Called at posedge+1; leaves us at posedge+1 just after the edge that ends the ack cycle.
    task automatic do_req(input logic [63:0] a, input logic [63:0] wd, input logic we,
                          input logic [1:0] sz, input bit keep,
                          output logic [63:0] rd, output logic er, output int cyc);
        bit got = 0;
        bus0.mem_req   = 1'b1;
        bus0.mem_addr  = a;
        bus0.mem_wdata = wd;
        bus0.mem_wen   = we;
        bus0.mem_size  = sz;
        cyc = 0;
        rd  = '0;
        er  = 1'b0;
        while (!got && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (bus0.mem_ack) begin
                got = 1;
                rd  = bus0.mem_rdata;
                er  = bus0.mem_err;
            end
        end
        @(posedge clk); #1;
        if (!keep) bus0.mem_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus0.mem_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", bus0.mem_ack); end
        checks++; if (bus0.mem_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus0.mem_err); end
        checks++; if (bus0.ext_req !== 1'b0) begin errors++; $display("FAIL reset_ext_req: got %b expected 0", bus0.ext_req); end
        checks++; if (bus0.mem_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus0.mem_rdata); end
        checks++; if (bus0.ext_addr !== 64'h0) begin errors++; $display("FAIL reset_ext_addr: got %h expected 0", bus0.ext_addr); end
        rst = 1'b0;
    endtask

    task automatic test_bram_basic();
        logic [63:0] rd; logic er; int cyc;
        do_req(64'h10, 64'h1122334455667788, 1'b1, 2'd3, 1'b0, rd, er, cyc);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL wr_latency: got %0d expected 1", cyc); end
        checks++; if (bus0.mem_ack !== 1'b0) begin errors++; $display("FAIL ack_pulse: got %b expected 0", bus0.mem_ack); end
        do_req(64'h12, 64'h0, 1'b0, 2'd1, 1'b0, rd, er, cyc);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL rd_latency: got %0d expected 2", cyc); end
        checks++; if (rd !== 64'h5566) begin errors++; $display("FAIL rd_half: got %h expected 5566", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err: got %b expected 0", er); end
    endtask

    task automatic test_byte_lanes();
        logic [63:0] rd; logic er; int cyc;
        do_req(64'h17, 64'hAB, 1'b1, 2'd0, 1'b0, rd, er, cyc);
        do_req(64'h10, 64'h0, 1'b0, 2'd3, 1'b0, rd, er, cyc);
        checks++; if (rd !== 64'hAB22334455667788) begin errors++; $display("FAIL byte_merge: got %h expected ab22334455667788", rd); end
        do_req(64'h13, 64'h0, 1'b0, 2'd2, 1'b0, rd, er, cyc);
        checks++; if (rd !== 64'h55667788) begin errors++; $display("FAIL misalign_word: got %h expected 55667788", rd); end
        do_req(64'h17, 64'h0, 1'b0, 2'd0, 1'b0, rd, er, cyc);
        checks++; if (rd !== 64'hAB) begin errors++; $display("FAIL rd_byte7: got %h expected ab", rd); end
    endtask

    task automatic test_ext_read();
        logic [63:0] rd; logic er; int cyc;
        ext_delay = 5; ext_hi_last = 0;
        bus0.ext_rdata = 64'hDEADBEEF00000000;
        do_req(64'h8000_0000, 64'h0, 1'b0, 2'd3, 1'b0, rd, er, cyc);
        checks++; if (ext_hi_last !== 5) begin errors++; $display("FAIL ext_req_cycles: got %0d expected 5", ext_hi_last); end
        checks++; if (cyc !== 6) begin errors++; $display("FAIL ext_latency: got %0d expected 6", cyc); end
        checks++; if (rd !== 64'hDEADBEEF00000000) begin errors++; $display("FAIL ext_rdata: got %h expected deadbeef00000000", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL ext_err: got %b expected 0", er); end
        checks++; if (ext_addr_seen !== 64'h8000_0000) begin errors++; $display("FAIL ext_addr: got %h expected 80000000", ext_addr_seen); end
        do_req(64'h8000_0006, 64'h0, 1'b0, 2'd1, 1'b0, rd, er, cyc);
        checks++; if (rd !== 64'hDEAD) begin errors++; $display("FAIL ext_half: got %h expected dead", rd); end
    endtask

    task automatic test_ext_write();
        logic [63:0] rd; logic er; int cyc;
        ext_delay = 2; ext_wen_seen = 1'b0;
        do_req(64'h8000_0010, 64'h1234, 1'b1, 2'd3, 1'b0, rd, er, cyc);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL extw_latency: got %0d expected 3", cyc); end
        checks++; if (rd !== 64'h0) begin errors++; $display("FAIL extw_rdata: got %h expected 0", rd); end
        checks++; if (ext_wen_seen !== 1'b1) begin errors++; $display("FAIL extw_wen: got %b expected 1", ext_wen_seen); end
    endtask

    task automatic test_timeout();
        logic [63:0] rd; logic er; int cyc;
        ext_delay = 0; ext_hi_last = 0;
        do_req(64'h8000_0020, 64'h0, 1'b0, 2'd3, 1'b0, rd, er, cyc);
        checks++; if (ext_hi_last !== 32) begin errors++; $display("FAIL to_req_cycles: got %0d expected 32", ext_hi_last); end
        checks++; if (cyc !== 33) begin errors++; $display("FAIL to_latency: got %0d expected 33", cyc); end
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", er); end
        checks++; if (rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL to_rdata: got %h expected ffffffffffffffff", rd); end
        checks++; if (bus0.mem_err !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b expected 0", bus0.mem_err); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] rd; logic er; int cyc; int ac0;
        ac0 = ack_count;
        do_req(64'h40, 64'hA5A5_0000_1111_2222, 1'b1, 2'd3, 1'b1, rd, er, cyc);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL b2b_wr0: got %0d expected 1", cyc); end
        do_req(64'h48, 64'h0BAD_F00D_3333_4444, 1'b1, 2'd3, 1'b1, rd, er, cyc);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL b2b_wr1: got %0d expected 1", cyc); end
        do_req(64'h40, 64'h0, 1'b0, 2'd3, 1'b1, rd, er, cyc);
        checks++; if (rd !== 64'hA5A5_0000_1111_2222) begin errors++; $display("FAIL b2b_rd0: got %h expected a5a5000011112222", rd); end
        do_req(64'h48, 64'h0, 1'b0, 2'd3, 1'b0, rd, er, cyc);
        checks++; if (rd !== 64'h0BAD_F00D_3333_4444) begin errors++; $display("FAIL b2b_rd1: got %h expected 0badf00d33334444", rd); end
        checks++; if (cyc !== 2) begin errors++; $display("FAIL b2b_rd_latency: got %0d expected 2", cyc); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ack_count - ac0 !== 4) begin errors++; $display("FAIL b2b_ack_count: got %0d expected 4", ack_count - ac0); end
    endtask

    task automatic test_wrap();
        int n = 0;
        bus1.mem_req = 1'b1; bus1.mem_addr = 64'h0FF8; bus1.mem_wen = 1'b0; bus1.mem_size = 2'd3;
        bus1.mem_wdata = 64'h0;
        @(posedge clk); #1;
        checks++; if (bus1.ext_req !== 1'b1) begin errors++; $display("FAIL wrap_ext_req: got %b expected 1", bus1.ext_req); end
        checks++; if (bus1.ext_addr !== 64'h0FF8) begin errors++; $display("FAIL wrap_ext_addr: got %h expected ff8", bus1.ext_addr); end
        while (bus1.mem_ack !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        checks++; if (n !== 8) begin errors++; $display("FAIL wrap_timeout_cycles: got %0d expected 8", n); end
        checks++; if (bus1.mem_err !== 1'b1) begin errors++; $display("FAIL wrap_err: got %b expected 1", bus1.mem_err); end
        @(posedge clk); #1;
        bus1.mem_addr = 64'h1000; bus1.mem_wen = 1'b1; bus1.mem_wdata = 64'h0123_4567_89AB_CDEF;
        @(posedge clk); #1;
        checks++; if ({bus1.mem_ack, bus1.ext_req} !== 2'b10) begin errors++; $display("FAIL base_write: got ack,ext_req=%b expected 10", {bus1.mem_ack, bus1.ext_req}); end
        @(posedge clk); #1;
        bus1.mem_wen = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (bus1.mem_ack !== 1'b1 || bus1.mem_rdata !== 64'h0123_4567_89AB_CDEF) begin
            errors++; $display("FAIL base_read: got ack=%b data=%h expected ack=1 data=0123456789abcdef", bus1.mem_ack, bus1.mem_rdata);
        end
        @(posedge clk); #1;
        bus1.mem_req = 1'b0;
    endtask

    task automatic test_reset_mid_ext();
        logic [63:0] rd; logic er; int cyc;
        ext_delay = 0;
        bus0.mem_req = 1'b1; bus0.mem_addr = 64'h9000_0000; bus0.mem_wen = 1'b0; bus0.mem_size = 2'd3;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus0.ext_req !== 1'b1) begin errors++; $display("FAIL rst_pre_ext_req: got %b expected 1", bus0.ext_req); end
        rst = 1'b1;
        #1;
        checks++; if ({bus0.ext_req, bus0.mem_ack, bus0.mem_err} !== 3'b000) begin
            errors++; $display("FAIL rst_mid_ext: got req,ack,err=%b expected 000", {bus0.ext_req, bus0.mem_ack, bus0.mem_err});
        end
        bus0.mem_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_req(64'h10, 64'h0, 1'b0, 2'd3, 1'b0, rd, er, cyc);
        checks++; if (rd !== 64'hAB22334455667788 || cyc !== 2) begin
            errors++; $display("FAIL rst_then_read: got data=%h cycles=%0d expected ab22334455667788 and 2", rd, cyc);
        end
    endtask

    initial begin
        bus0.mem_req = 1'b0; bus0.mem_addr = '0; bus0.mem_wdata = '0; bus0.mem_wen = 1'b0;
        bus0.mem_size = '0; bus0.ext_rdata = '0;
        bus1.mem_req = 1'b0; bus1.mem_addr = '0; bus1.mem_wdata = '0; bus1.mem_wen = 1'b0;
        bus1.mem_size = '0; bus1.ext_rdata = '0; bus1.ext_ack = 1'b0;
        test_reset();
        test_bram_basic();
        test_byte_lanes();
        test_ext_read();
        test_ext_write();
        test_timeout();
        test_back_to_back();
        test_wrap();
        test_reset_mid_ext();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
